// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: parametrised, pipelined carry-lookahead adder/subtractor
// with valid/ready handshake on both sides.
//
// Stage k completes result slice [k*WIDTH/STAGES +: WIDTH/STAGES] using
// GROUP-wise lookahead, starting from the carry registered by stage k-1.
// Stage 0 works directly from the input operands; the last stage's registers
// drive the outputs with no logic after the flops.
//
// Optional feature: define CLA_PIPE_ADDER_FLAGS_EN to compute and register the
// overflow / zero / negative status flags. Without it they are tied to 0.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW   = WIDTH / STAGES;   // bits completed per stage
    localparam int NG   = SW / GROUP;       // lookahead groups per stage
    localparam int LAST = STAGES - 1;

    // One slice of carry-lookahead addition: per-group generate/propagate,
    // group carries by lookahead from c0, bit carries inside each group.
    // Returns {carry_out, slice_sum}.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          c0);
        logic [SW-1:0] g, p, s;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          t, bc;
        g = x & y;
        p = x ^ y;
        s = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = 1'b0;
            gp[j] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
                gp[j] = gp[j] & p[j*GROUP+i];
            end
        end
        gc[0] = c0;
        for (int j = 1; j <= NG; j++) begin
            t = c0;
            for (int m = 0; m < j; m++) t = t & gp[m];
            gc[j] = t;
            for (int i = 0; i < j; i++) begin
                t = gg[i];
                for (int m = i + 1; m < j; m++) t = t & gp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < NG; j++) begin
            bc = gc[j];
            for (int i = 0; i < GROUP; i++) begin
                s[j*GROUP+i] = p[j*GROUP+i] ^ bc;
                bc = g[j*GROUP+i] | (p[j*GROUP+i] & bc);
            end
        end
        return {gc[NG], s};
    endfunction

    // Stage registers
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  s_r [STAGES];
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];

    // Stage inputs and next values
    logic [STAGES-1:0] load, src_v, src_c, nxt_c;
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [SW:0]       slice_res [STAGES];

    // Select each stage's source: effective operands for stage 0, the previous stage's registers otherwise
    always_comb begin
        // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub | cin;
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_r[k-1];
            src_a[k] = a_r[k-1];
            src_b[k] = b_r[k-1];
            src_c[k] = c_r[k-1];
            src_s[k] = s_r[k-1];
        end
    end

    // Complete this stage's slice from its source carry
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_res[k] = cla_slice(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
            nxt_s[k]     = src_s[k];
            nxt_s[k][k*SW +: SW] = slice_res[k][SW-1:0];
            nxt_c[k]     = slice_res[k][SW];
        end
    end

    // Stage k loads when it or any later stage is empty, or the consumer takes the result
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            load[k] = out_ready;
            for (int j = k; j < STAGES; j++) load[k] = load[k] | ~v_r[j];
        end
    end

    assign in_ready = load[0] & ~rst;

    // Pipeline registers: advance each stage that loads, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r <= '0;
            c_r <= '0;
            // NOTE: data registers are cleared too, so outputs read 0 after reset rather than stale values.
            for (int k = 0; k < STAGES; k++) begin
                s_r[k] <= '0;
                a_r[k] <= '0;
                b_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
                    v_r[k] <= src_v[k];
                    s_r[k] <= nxt_s[k];
                    a_r[k] <= src_a[k];
                    b_r[k] <= src_b[k];
                    c_r[k] <= nxt_c[k];
                end
            end
        end
    end

    assign out_valid = v_r[LAST];
    assign sum       = s_r[LAST];
    assign cout      = c_r[LAST];

`ifdef CLA_PIPE_ADDER_FLAGS_EN
    logic ovf_r, zero_r, neg_r;
    logic a_msb, b_msb, s_msb;

    assign a_msb = src_a[LAST][WIDTH-1];
    assign b_msb = src_b[LAST][WIDTH-1];
    assign s_msb = nxt_s[LAST][WIDTH-1];

    // Status flags registered alongside the final sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else if (load[LAST]) begin
            ovf_r  <= (a_msb == b_msb) && (s_msb != a_msb);
            zero_r <= (nxt_s[LAST] == '0);
            neg_r  <= s_msb;
        end
    end

    assign overflow = ovf_r;
    assign zero     = zero_r;
    assign negative = neg_r;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: main instance (WIDTH=32, STAGES=2) plus
// STAGES=1 / 3 (WIDTH=48) / 4 instances sharing the same stimulus, each with
// its own scoreboard queue.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_ADDER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    localparam int W [4] = '{32, 32, 48, 32};
    localparam int S [4] = '{2, 1, 3, 4};

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    logic [3:0]  rdy, ov, co, of, zf, ng;
    logic [31:0] s0, s1, s3;
    logic [47:0] s2;
    logic [63:0] sm [4];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out [4] = '{0, 0, 0, 0};
    exp_t sbq [4][$];

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]),
        .overflow(of[0]), .zero(zf[0]), .negative(ng[0]));

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]),
        .overflow(of[1]), .zero(zf[1]), .negative(ng[1]));

    cla_pipe_adder #(.WIDTH(48), .GROUP(4), .STAGES(3)) dut_s3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a[47:0]), .b(b[47:0]), .cin(cin), .sub(sub),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]),
        .overflow(of[2]), .zero(zf[2]), .negative(ng[2]));

    cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov[3]), .out_ready(out_ready), .sum(s3), .cout(co[3]),
        .overflow(of[3]), .zero(zf[3]), .negative(ng[3]));

    always_comb begin
        sm[0] = {32'b0, s0};
        sm[1] = {32'b0, s1};
        sm[2] = {16'b0, s2};
        sm[3] = {32'b0, s3};
    end

    // Reference: a + (sub ? ~b : b) + (sub ? 1 : cin) at width w
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic su, input int w);
        logic [64:0] m, r;
        logic [63:0] bp;
        exp_t        e;
        m      = (65'd1 << w) - 65'd1;
        bp     = su ? ~y : y;
        r      = ({1'b0, x} & m) + ({1'b0, bp} & m) + (su ? 65'd1 : {64'd0, ci});
        e.sum  = r[63:0] & m[63:0];
        e.cout = r[w];
        e.neg  = FL & e.sum[w-1];
        e.zero = FL & (e.sum == 64'd0);
        e.ovf  = FL & (x[w-1] == bp[w-1]) & (e.sum[w-1] != x[w-1]);
        return e;
    endfunction

    // Scoreboard: push on accepted input, pop and compare on accepted output
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 4; d++) sbq[d].delete();
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (in_valid && rdy[d]) sbq[d].push_back(model(a, b, cin, sub, W[d]));
                if (ov[d] && out_ready) begin
                    exp_t e, g;
                    g.sum = sm[d]; g.cout = co[d]; g.ovf = of[d]; g.zero = zf[d]; g.neg = ng[d];
                    n_cmp++;
                    if (sbq[d].size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected dut%0d: got sum=%h while nothing outstanding", d, sm[d]);
                    end else begin
                        e = sbq[d].pop_front();
                        n_out[d]++;
                        if (g !== e) begin
                            n_bad++;
                            $display("FAIL sb_result dut%0d: got sum=%h cout=%b ovf/zero/neg=%b%b%b, want sum=%h cout=%b ovf/zero/neg=%b%b%b",
                                     d, g.sum, g.cout, g.ovf, g.zero, g.neg, e.sum, e.cout, e.ovf, e.zero, e.neg);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and return just after the edge that transfers it into the main instance
    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic su);
        a = x; b = y; cin = ci; sub = su; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy[0]) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: in_ready never rose within 50 cycles");
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        n_cmp++;
        if ({ov[0], s0, co[0], of[0], zf[0], ng[0], rdy[0]} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b sum=%h cout=%b flags=%b%b%b in_ready=%b, want all 0",
                     ov[0], s0, co[0], of[0], zf[0], ng[0], rdy[0]);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", rdy[0]); end

        // Two operations in flight, consumer stalled, then reset
        out_ready = 1'b0;
        send(64'h1111, 64'h2222, 1'b0, 1'b0);
        send(64'h3333, 64'h4444, 1'b0, 1'b0);
        n_cmp++;
        if ({ov[0], rdy[0]} !== 2'b10) begin
            n_bad++; $display("FAIL full_stall: got valid/in_ready=%b%b want 10", ov[0], rdy[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ov[0], s0, co[0], of[0], zf[0], ng[0], rdy[0]} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_async: got valid=%b sum=%h cout=%b flags=%b%b%b in_ready=%b, want all 0",
                     ov[0], s0, co[0], of[0], zf[0], ng[0], rdy[0]);
        end
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ready: got %b want 1", rdy[0]); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (ov !== 4'b0) begin n_bad++; $display("FAIL reset_no_stale: got out_valid=%b want 0000", ov); end
        end
    endtask

    typedef struct {
        logic [31:0] x, y;
        logic        ci, su;
        logic [31:0] s;
        logic        c, o, z, n;
    } vec_t;

    task automatic test_arith();
        vec_t v [8];
        v[0] = '{32'hFFFF_FFFF, 32'h1,          1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b0};
        v[1] = '{32'h0000_FFFF, 32'h1,          1'b0, 1'b0, 32'h0001_0000,  1'b0, 1'b0, 1'b0, 1'b0};
        v[2] = '{32'h7FFF_FFFF, 32'h1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1, 1'b0, 1'b1};
        v[3] = '{32'd5,         32'd7,          1'b1, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 1'b1};
        v[4] = '{32'd7,         32'd5,          1'b0, 1'b1, 32'd2,          1'b1, 1'b0, 1'b0, 1'b0};
        v[5] = '{32'h1234_5678, 32'h1111_1111,  1'b1, 1'b0, 32'h2345_678A,  1'b0, 1'b0, 1'b0, 1'b0};
        v[6] = '{32'h8000_0000, 32'h1,          1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0};
        v[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send({32'h0, v[i].x}, {32'h0, v[i].y}, v[i].ci, v[i].su);
            tick();
            n_cmp++;
            if ({ov[0], s0, co[0]} !== {1'b1, v[i].s, v[i].c}) begin
                n_bad++;
                $display("FAIL arith_sum[%0d]: got valid=%b sum=%h cout=%b, want valid=1 sum=%h cout=%b",
                         i, ov[0], s0, co[0], v[i].s, v[i].c);
            end
            n_cmp++;
            if ({of[0], zf[0], ng[0]} !== ({v[i].o, v[i].z, v[i].n} & {3{FL}})) begin
                n_bad++;
                $display("FAIL arith_flags[%0d]: got ovf/zero/neg=%b%b%b want %b",
                         i, of[0], zf[0], ng[0], {v[i].o, v[i].z, v[i].n} & {3{FL}});
            end
        end
        tick();
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        a = 64'h0000_1234_0000_0042; b = 64'h0000_0000_0000_0100; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            in_valid = 1'b0;
            for (int d = 0; d < 4; d++) begin
                n_cmp++;
                if (ov[d] !== (i == S[d])) begin
                    n_bad++;
                    $display("FAIL latency dut%0d edge%0d: got out_valid=%b want %b", d, i, ov[d], (i == S[d]));
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int          idx;
        int          base;
        logic        r;
        logic [31:0] held;
        out_ready = 1'b0;
        idx = 0;
        base = n_out[0];
        a = 64'h1000; b = 64'd0; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            r = rdy[0];
            n_cmp++;
            if (r !== (c < 2)) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", c, r, (c < 2)); end
            if (c == 2) held = s0;
            tick();
            if (r) begin idx++; a = 64'h1000 * (idx + 1); b = 64'(idx); end
        end
        n_cmp++;
        if (idx !== 2 || s0 !== held || ov[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold: got accepts=%0d sum=%h valid=%b, want accepts=2 sum=%h valid=1", idx, s0, ov[0], held);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            r = rdy[0];
            tick();
            if (r) begin idx++; a = 64'h1000 * (idx + 1); b = 64'(idx); end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (n_out[0] - base !== 4 || sbq[0].size() !== 0) begin
            n_bad++;
            $display("FAIL bp_order: got %0d results, %0d outstanding; want 4 results, 0 outstanding",
                     n_out[0] - base, sbq[0].size());
        end

        // Streaming: one operation per cycle with the consumer always ready
        base = n_out[0];
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            a = 64'(32'hABC0_0000 + c); b = 64'(c * 3);
            @(negedge clk);
            n_cmp++;
            if (rdy[0] !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready cyc%0d: got %b want 1", c, rdy[0]); end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (n_out[0] - base !== 8) begin
            n_bad++; $display("FAIL stream_count: got %0d results want 8", n_out[0] - base);
        end
    endtask

    task automatic test_random();
        int start [4];
        for (int d = 0; d < 4; d++) start[d] = n_out[d];
        for (int c = 0; c < 10000; c++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) a = '1;
            if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) == 1) ? '1 : 64'd1;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (sbq[d].size() !== 0 || n_out[d] - start[d] < 1000) begin
                n_bad++;
                $display("FAIL random_drain dut%0d: got %0d outstanding, %0d results; want 0 outstanding, >=1000 results",
                         d, sbq[d].size(), n_out[d] - start[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_latency();
        test_back_pressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
